bridge_bus_master: RTL and testbench

Single-outstanding-transfer initiator for the 16-bit external bridge bus (`bridge_memory_*`) exported by the platform system. It accepts read/write commands from fabric logic (pong game engine, sprite/frame writers) on a valid/ready interface. It drives one bus transfer at a time and holds the strobe until `acknowledge`. It then returns read data and status on a valid/ready response channel.

---
 rtl/bridge_bus_pkg.sv | 15 +
 rtl/bridge_ack_timer.sv | 36 +++
 rtl/bridge_bus_master.sv | 158 +++++++++++++++
 tb/tb_bridge_bus_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_bus_pkg.sv
// Shared types and default widths for the bridge bus master and its ack timer.
package bridge_bus_pkg;

    localparam int unsigned DefAddrW         = 27;
    localparam int unsigned DefDataW         = 16;
    localparam int unsigned DefBeW           = DefDataW / 8;
    localparam int unsigned DefTimeoutCycles = 1024;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StRsp  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bridge_ack_timer.sv
// Counts strobe cycles of the current bridge transfer and flags when the ack wait expires.
module bridge_ack_timer #(
    parameter int unsigned Cycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Cycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // The count equals the number of strobe cycles seen so far, so the first strobe cycle is 1.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(1);
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign expired_o = (cnt_q >= CntW'(Cycles));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bridge_bus_master.sv
// Single-outstanding initiator for the 16-bit bridge bus with a valid/ready command/response pair.
// Optional ack timeout is enabled by defining BRIDGE_TIMEOUT_EN.
module bridge_bus_master
    import bridge_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned BE_W           = DefBeW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BE_W-1:0]   cmd_be,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] bridge_memory_address,
    output logic [BE_W-1:0]   bridge_memory_byte_enable,
    output logic              bridge_memory_read,
    output logic              bridge_memory_write,
    output logic [DATA_W-1:0] bridge_memory_write_data,
    input  logic              bridge_memory_acknowledge,
    input  logic [DATA_W-1:0] bridge_memory_read_data,
    output logic              busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              tmr_load;
    logic              tmo_expired;

`ifdef BRIDGE_TIMEOUT_EN
    bridge_ack_timer #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .load_i    (tmr_load),
        .inc_i     (state_q == StBus),
        .expired_o (tmo_expired)
    );
`else
    // Without the timer the error flag can never be set and stays constant 0.
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmr_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_write && (cmd_be == '0)) begin
                        // Nothing to write: answer at once without touching the bus.
                        state_d     = StRsp;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d  = StBus;
                        addr_d   = cmd_addr & ~ADDR_W'(1);
                        be_d     = cmd_write ? cmd_be : '1;
                        wdata_d  = cmd_write ? cmd_wdata : '0;
                        rd_d     = !cmd_write;
                        wr_d     = cmd_write;
                        tmr_load = 1'b1;
                    end
                end
            end
            StBus: begin
                // An ack arriving on the expiry edge still completes the transfer normally.
                if (bridge_memory_acknowledge || tmo_expired) begin
                    state_d     = StRsp;
                    addr_d      = '0;
                    be_d        = '0;
                    wdata_d     = '0;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (bridge_memory_acknowledge && rd_q) ?
                                  bridge_memory_read_data : '0;
                    rsp_err_d   = !bridge_memory_acknowledge;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready                 = (state_q == StIdle);
    assign busy                      = (state_q != StIdle);
    assign bridge_memory_address     = addr_q;
    assign bridge_memory_byte_enable = be_q;
    assign bridge_memory_write_data  = wdata_q;
    assign bridge_memory_read        = rd_q;
    assign bridge_memory_write       = wr_q;
    assign rsp_valid                 = rsp_valid_q;
    assign rsp_rdata                 = rsp_rdata_q;
    assign rsp_error                 = rsp_err_q;

endmodule

// File: tb/tb_bridge_bus_master.sv
// Directed bench for bridge_bus_master; timeout steps run when BRIDGE_TIMEOUT_EN is defined.
module tb_bridge_bus_master;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [26:0] cmd_addr = '0;
    logic [1:0]  cmd_be = '0;
    logic [15:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic [26:0] bridge_memory_address;
    logic [1:0]  bridge_memory_byte_enable;
    logic        bridge_memory_read;
    logic        bridge_memory_write;
    logic [15:0] bridge_memory_write_data;
    logic        bridge_memory_acknowledge = 1'b0;
    logic [15:0] bridge_memory_read_data = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n;

    bridge_bus_master #(
        .ADDR_W         (27),
        .DATA_W         (16),
        .BE_W           (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_clk                   (clk_clk),
        .reset_reset_n             (reset_reset_n),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_write                 (cmd_write),
        .cmd_addr                  (cmd_addr),
        .cmd_be                    (cmd_be),
        .cmd_wdata                 (cmd_wdata),
        .rsp_valid                 (rsp_valid),
        .rsp_ready                 (rsp_ready),
        .rsp_rdata                 (rsp_rdata),
        .rsp_error                 (rsp_error),
        .bridge_memory_address     (bridge_memory_address),
        .bridge_memory_byte_enable (bridge_memory_byte_enable),
        .bridge_memory_read        (bridge_memory_read),
        .bridge_memory_write       (bridge_memory_write),
        .bridge_memory_write_data  (bridge_memory_write_data),
        .bridge_memory_acknowledge (bridge_memory_acknowledge),
        .bridge_memory_read_data   (bridge_memory_read_data),
        .busy                      (busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(bridge_memory_read), 32'd0);
        chk("rst_write", 32'(bridge_memory_write), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_addr", 32'(bridge_memory_address), 32'd0);
        tick();
        reset_reset_n = 1'b1;
        tick();

        // Read 0x123, ack sampled on the third strobe edge
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h0000123; cmd_be = 2'b00;
        tick();
        cmd_valid = 1'b0;
        chk("rd_strobe_c1", 32'(bridge_memory_read), 32'd1);
        chk("rd_no_write", 32'(bridge_memory_write), 32'd0);
        chk("rd_addr", 32'(bridge_memory_address), 32'h0000122);
        chk("rd_be", 32'(bridge_memory_byte_enable), 32'd3);
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("rd_strobe_c2", 32'(bridge_memory_read), 32'd1);
        tick();
        chk("rd_strobe_c3", 32'(bridge_memory_read), 32'd1);
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'hBEEF;
        tick();
        bridge_memory_acknowledge = 1'b0; bridge_memory_read_data = 16'h0000;
        chk("rd_strobe_drop", 32'(bridge_memory_read), 32'd0);
        chk("rd_addr_clear", 32'(bridge_memory_address), 32'd0);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rdata", 32'(rsp_rdata), 32'hBEEF);
        chk("rd_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_rsp_done", 32'(rsp_valid), 32'd0);
        chk("rd_idle_ready", 32'(cmd_ready), 32'd1);

        // Write 0x40 be=01, ack in the first strobe cycle
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 27'h0000040; cmd_be = 2'b01;
        cmd_wdata = 16'hA55A;
        tick();
        cmd_valid = 1'b0;
        chk("wr_strobe", 32'(bridge_memory_write), 32'd1);
        chk("wr_no_read", 32'(bridge_memory_read), 32'd0);
        chk("wr_addr", 32'(bridge_memory_address), 32'h0000040);
        chk("wr_be", 32'(bridge_memory_byte_enable), 32'd1);
        chk("wr_wdata", 32'(bridge_memory_write_data), 32'hA55A);
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'h7777;
        tick();
        bridge_memory_acknowledge = 1'b0;
        chk("wr_strobe_drop", 32'(bridge_memory_write), 32'd0);
        chk("wr_wdata_clear", 32'(bridge_memory_write_data), 32'd0);
        chk("wr_be_clear", 32'(bridge_memory_byte_enable), 32'd0);
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rdata", 32'(rsp_rdata), 32'd0);
        chk("wr_error", 32'(rsp_error), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_rsp_done", 32'(rsp_valid), 32'd0);

        // Skipped write (be=00), then back-pressure with a pending read command
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 27'h0000100; cmd_be = 2'b00;
        cmd_wdata = 16'h1234;
        tick();
        chk("skip_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("skip_no_write", 32'(bridge_memory_write), 32'd0);
        chk("skip_error", 32'(rsp_error), 32'd0);
        chk("skip_rdata", 32'(rsp_rdata), 32'd0);
        cmd_write = 1'b0; cmd_addr = 27'h0000201;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_no_strobe", 32'({bridge_memory_read, bridge_memory_write}), 32'd0);
            chk("bp_rdata", 32'(rsp_rdata), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_cycle", 32'(bridge_memory_read), 32'd0);
        chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_next_read", 32'(bridge_memory_read), 32'd1);
        chk("bp_next_addr", 32'(bridge_memory_address), 32'h0000200);
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'h1234;
        tick();
        bridge_memory_acknowledge = 1'b0; bridge_memory_read_data = 16'h0000;
        chk("bp_rd_rdata", 32'(rsp_rdata), 32'h1234);
        tick();
        rsp_ready = 1'b0;
        chk("bp_rd_done", 32'(rsp_valid), 32'd0);

        // Spurious ack while idle
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'hFFFF;
        tick();
        tick();
        bridge_memory_acknowledge = 1'b0;
        chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("spur_rdata_held", 32'(rsp_rdata), 32'h1234);
        chk("spur_strobe", 32'({bridge_memory_read, bridge_memory_write}), 32'd0);
        chk("spur_ready", 32'(cmd_ready), 32'd1);

        // Reset asserted mid-transfer
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 27'h0000080; cmd_be = 2'b11;
        cmd_wdata = 16'h1111;
        tick();
        cmd_valid = 1'b0;
        chk("mrst_strobe_on", 32'(bridge_memory_write), 32'd1);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("mrst_strobe_off", 32'(bridge_memory_write), 32'd0);
        chk("mrst_addr", 32'(bridge_memory_address), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        tick();
        reset_reset_n = 1'b1;
        tick();
        tick();
        chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_no_strobe", 32'(bridge_memory_write), 32'd0);

`ifdef BRIDGE_TIMEOUT_EN
        // No ack: strobe for exactly 8 cycles, then an error response
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h0000010;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (bridge_memory_read && n < 20) begin
            n++;
            tick();
        end
        chk("tmo_strobe_len", 32'(n), 32'd8);
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_error", 32'(rsp_error), 32'd1);
        chk("tmo_rdata", 32'(rsp_rdata), 32'd0);
        tick();
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'hCAFE;
        tick();
        bridge_memory_acknowledge = 1'b0;
        chk("tmo_late_error", 32'(rsp_error), 32'd1);
        chk("tmo_late_rdata", 32'(rsp_rdata), 32'd0);
        chk("tmo_late_strobe", 32'(bridge_memory_read), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tmo_rsp_done", 32'(rsp_valid), 32'd0);

        // Ack on the expiry edge wins
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 27'h0000020;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("race_strobe_c8", 32'(bridge_memory_read), 32'd1);
        bridge_memory_acknowledge = 1'b1; bridge_memory_read_data = 16'h5A5A;
        tick();
        bridge_memory_acknowledge = 1'b0;
        chk("race_strobe_drop", 32'(bridge_memory_read), 32'd0);
        chk("race_error", 32'(rsp_error), 32'd0);
        chk("race_rdata", 32'(rsp_rdata), 32'h5A5A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
